qbus_host_seq: RTL

Q-bus master cycle sequencer for exercising and servicing 1801VP1-065 serial controllers. It arbitrates between two local requesters and the bus interrupt line nVIRQ, then runs DATI (read), DATO (write) or INTA (vector fetch) cycles on the nAD/nSYNC/nDIN/nDOUT/nBS/nIAKO/nRPLY signals. It sits between a host-side controller and the multiplexed Q-bus, in place of the hand-written bus tasks.

---
 rtl/qbus_pkg.sv | 36 +++
 rtl/qbus_rr_arb.sv | 56 +++++
 rtl/qbus_host_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/qbus_pkg.sv
// qbus_pkg
// Shared definitions for the Q-bus host cycle sequencer:
//   - qbus_state_e : bus phase encoding, one phase per clock
//   - qbus_cycle_e : kind of cycle currently running (DATI / DATO / INTA)
//   - IOPAGE_HI    : top address bits that select the I/O page (nBS asserted)
//   - STROBE_IDLE  : released level of the active-low strobes
//   - AD_IDLE      : value presented on ad_do when nothing is driven
package qbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SYNC,
    ST_DATA,
    ST_WAIT_RPLY,
    ST_LATCH,
    ST_WAIT_NRPLY,
    ST_DONE
  } qbus_state_e;

  typedef enum logic [1:0] {
    CYC_DATI,
    CYC_DATO,
    CYC_INTA
  } qbus_cycle_e;

  localparam logic [2:0]  IOPAGE_HI   = 3'b111;
  localparam logic        STROBE_IDLE = 1'b1;
  localparam logic [15:0] AD_IDLE     = 16'hFFFF;

  // An address in the top 8 KB of the 16-bit space belongs to the I/O page.
  function automatic logic is_iopage(input logic [15:0] addr);
    return addr[15:13] == IOPAGE_HI;
  endfunction

endpackage

// File: rtl/qbus_rr_arb.sv
// qbus_rr_arb
// Two-way round-robin arbiter with an interrupt override.
//   clk, reset : system clock, synchronous active-high reset
//   req[1:0]   : local requester requests
//   irq        : qualified interrupt request (already gated by IRQ_EN)
//   take       : the sequencer accepts the current grant this clock
//   gnt_vld    : some grant is available
//   gnt_inta   : the grant is an interrupt acknowledge cycle
//   gnt_idx    : requester index when gnt_inta is low
// The last-grant pointer only moves when a requester grant is taken, so an
// interrupt cycle does not disturb fairness between the two requesters.
module qbus_rr_arb
  import qbus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       irq,
  input  logic       take,
  output logic       gnt_vld,
  output logic       gnt_inta,
  output logic       gnt_idx
);

  logic last_gnt;

  // Interrupt beats both requesters; on a tie the requester that was not
  // granted last time wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_inta = 1'b0;
    gnt_idx  = 1'b0;
    if (irq) begin
      gnt_vld  = 1'b1;
      gnt_inta = 1'b1;
    end else if (req[0] && req[1]) begin
      gnt_vld = 1'b1;
      gnt_idx = ~last_gnt;
    end else if (req[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b0;
    end else if (req[1]) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b0;
    end else if (take && gnt_vld && !gnt_inta) begin
      last_gnt <= gnt_idx;
    end
  end

endmodule

// File: rtl/qbus_host_seq.sv
// qbus_host_seq
// Q-bus master cycle sequencer: arbitrates two local requesters and nVIRQ,
// then runs DATI, DATO or INTA cycles one bus phase per clock.
//   clk, reset          : system clock, synchronous active-high reset
//   req/req_we          : per-requester request and direction (1 = write)
//   req_addr/req_wdata  : requester n fields at [16n+15:16n], true polarity
//   ack, rdata, err     : completion pulse, read data, timeout flag
//   irq_vld, irq_vec    : INTA completion pulse and fetched vector
//   busy                : a cycle is in progress
//   ad_do, ad_oe, ad_di : multiplexed nAD bus (active-low values)
//   nSYNC nDIN nDOUT nBS nIAKO : active-low strobes driven by the master
//   nRPLY nVIRQ         : active-low reply and interrupt request inputs
// Build option: define QBUS_RPLY_SYNC_EN to pass nRPLY and nVIRQ through
// two-flop synchronizers when the bus is asynchronous to clk.
module qbus_host_seq #(
  parameter int unsigned TMO_CYCLES = 255,
  parameter bit          IRQ_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        irq_vld,
  output logic [15:0] irq_vec,
  output logic        busy,
  output logic [15:0] ad_do,
  output logic        ad_oe,
  input  logic [15:0] ad_di,
  output logic        nSYNC,
  output logic        nDIN,
  output logic        nDOUT,
  output logic        nBS,
  output logic        nIAKO,
  input  logic        nRPLY,
  input  logic        nVIRQ
);

  import qbus_pkg::*;

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  qbus_state_e state, state_nxt;
  qbus_cycle_e cyc;
  logic        idx;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        bs_low;
  logic [15:0] tmo_cnt;
  logic        tmo_err;
  logic        tmo_hit;
  logic        rply_n_s;
  logic        virq_n_s;
  logic        gnt_vld;
  logic        gnt_inta;
  logic        gnt_idx;
  logic [15:0] gnt_addr;

`ifdef QBUS_RPLY_SYNC_EN
  logic [1:0] rply_sync;
  logic [1:0] virq_sync;

  // Two-flop synchronizers; they idle at the released (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rply_sync <= 2'b11;
      virq_sync <= 2'b11;
    end else begin
      rply_sync <= {rply_sync[0], nRPLY};
      virq_sync <= {virq_sync[0], nVIRQ};
    end
  end

  assign rply_n_s = rply_sync[1];
  assign virq_n_s = virq_sync[1];
`else
  assign rply_n_s = nRPLY;
  assign virq_n_s = nVIRQ;
`endif

  qbus_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .irq      (IRQ_EN && !virq_n_s),
    .take     (state == ST_IDLE),
    .gnt_vld  (gnt_vld),
    .gnt_inta (gnt_inta),
    .gnt_idx  (gnt_idx)
  );

  assign gnt_addr = gnt_idx ? req_addr[31:16] : req_addr[15:0];
  assign busy     = (state != ST_IDLE);

  // Phase sequencing. A reply seen on the same clock as the timeout limit
  // still counts as a good reply.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE:      if (gnt_vld) state_nxt = ST_ADDR;
      ST_ADDR:      state_nxt = ST_SYNC;
      ST_SYNC:      state_nxt = ST_DATA;
      ST_DATA:      state_nxt = ST_WAIT_RPLY;
      ST_WAIT_RPLY: begin
        if (!rply_n_s) begin
          state_nxt = ST_LATCH;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_LATCH:     state_nxt = ST_WAIT_NRPLY;
      ST_WAIT_NRPLY: begin
        if (rply_n_s) begin
          state_nxt = ST_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register, grant latches, timeout counter and read-data capture.
  // The wait states are only ever entered from DATA or LATCH, so clearing
  // the counter there gives a fresh count on each wait entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cyc     <= CYC_DATI;
      idx     <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      bs_low  <= 1'b0;
      tmo_cnt <= 16'h0000;
      tmo_err <= 1'b0;
      rdata   <= 16'h0000;
      irq_vec <= 16'h0000;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && gnt_vld) begin
        idx     <= gnt_idx;
        tmo_err <= 1'b0;
        if (gnt_inta) begin
          cyc     <= CYC_INTA;
          addr_q  <= 16'h0000;
          wdata_q <= 16'h0000;
          bs_low  <= 1'b0;
        end else begin
          cyc     <= req_we[gnt_idx] ? CYC_DATO : CYC_DATI;
          addr_q  <= gnt_addr;
          wdata_q <= gnt_idx ? req_wdata[31:16] : req_wdata[15:0];
          bs_low  <= is_iopage(gnt_addr);
        end
      end

      if (state == ST_DATA || state == ST_LATCH) begin
        tmo_cnt <= 16'h0000;
      end else if (state == ST_WAIT_RPLY || state == ST_WAIT_NRPLY) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (state == ST_LATCH) begin
        if (cyc == CYC_DATI) rdata   <= ~ad_di;
        if (cyc == CYC_INTA) irq_vec <= ~ad_di;
      end

      if (tmo_hit) begin
        tmo_err <= 1'b1;
        if (cyc == CYC_DATI) rdata   <= 16'h0000;
        if (cyc == CYC_INTA) irq_vec <= 16'h0000;
      end
    end
  end

  // Bus strobes and completion pulses decoded from the current phase.
  // Write data stays on the bus through WAIT_NRPLY for slave hold time.
  always_comb begin
    nSYNC   = STROBE_IDLE;
    nDIN    = STROBE_IDLE;
    nDOUT   = STROBE_IDLE;
    nBS     = STROBE_IDLE;
    nIAKO   = STROBE_IDLE;
    ad_oe   = 1'b0;
    ad_do   = AD_IDLE;
    ack     = 2'b00;
    err     = 1'b0;
    irq_vld = 1'b0;
    case (state)
      ST_ADDR, ST_SYNC: begin
        nBS = ~bs_low;
        if (state == ST_SYNC) nSYNC = 1'b0;
        if (cyc != CYC_INTA) begin
          ad_oe = 1'b1;
          ad_do = ~addr_q;
        end
      end
      ST_DATA, ST_WAIT_RPLY, ST_LATCH: begin
        nBS   = ~bs_low;
        nSYNC = 1'b0;
        if (state != ST_DATA) begin
          nDOUT = (cyc == CYC_DATO) ? 1'b0 : 1'b1;
          nDIN  = (cyc == CYC_DATO) ? 1'b1 : 1'b0;
          nIAKO = (cyc == CYC_INTA) ? 1'b0 : 1'b1;
        end
        if (cyc == CYC_DATO) begin
          ad_oe = 1'b1;
          ad_do = ~wdata_q;
        end
      end
      ST_WAIT_NRPLY: begin
        nBS = ~bs_low;
        if (cyc == CYC_DATO) begin
          ad_oe = 1'b1;
          ad_do = ~wdata_q;
        end
      end
      ST_DONE: begin
        err = tmo_err;
        if (cyc == CYC_INTA) begin
          irq_vld = 1'b1;
        end else begin
          ack = idx ? 2'b10 : 2'b01;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
